psx_pad_ctrl: RTL and testbench



---
 rtl/psx_pad_ctrl_pkg.sv | 72 +++++++
 rtl/psx_pad_ctrl_if.sv | 25 ++
 rtl/psx_pad_ctrl_shifter.sv | 98 +++++++++
 rtl/psx_pad_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_psx_pad_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psx_pad_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pad_pkg
// Purpose  : Shared types and constants for the PlayStation pad poller:
//            FSM state encoding, poll command bytes, pad ID bytes, button bit
//            positions and the pad-to-NES mapping helper.
// Config   : PAD_ANALOG_EN extends the frame to 9 bytes (analog stick bytes).
// Revision : 1.0 - initial release
// ============================================================================
package pad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_ACKWAIT = 3'd3,
    ST_CHECK   = 3'd4,
    ST_FAIL    = 3'd5,
    ST_DONE    = 3'd6
  } pad_state_t;

  // Poll frame command bytes: start, "read data", then idle fill bytes.
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;
  localparam logic [7:0] CMD_IDLE  = 8'h00;

  localparam logic [7:0] ID_DIGITAL = 8'h41;
  localparam logic [7:0] ID_ANALOG  = 8'h73;
  localparam logic [7:0] ID_READY   = 8'h5A;

`ifdef PAD_ANALOG_EN
  localparam int NUM_BYTES = 9;
`else
  localparam int NUM_BYTES = 5;
`endif

  // Button bit positions inside response byte r3.
  localparam int BIT_SELECT = 0;
  localparam int BIT_START  = 3;
  localparam int BIT_UP     = 4;
  localparam int BIT_RIGHT  = 5;
  localparam int BIT_DOWN   = 6;
  localparam int BIT_LEFT   = 7;
  // Button bit positions inside response byte r4.
  localparam int BIT_CIRCLE = 5;
  localparam int BIT_CROSS  = 6;

  // Command byte sent at a given position in the frame.
  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = CMD_IDLE;
    if (idx == 4'd0) b = CMD_START;
    else if (idx == 4'd1) b = CMD_POLL;
    return b;
  endfunction

  // Pad response bits are active-low; NES image is active-high.
  function automatic logic [7:0] nes_map(input logic [7:0] r3, input logic [7:0] r4);
    logic [7:0] n;
    n[0] = ~r4[BIT_CIRCLE];
    n[1] = ~r4[BIT_CROSS];
    n[2] = ~r3[BIT_SELECT];
    n[3] = ~r3[BIT_START];
    n[4] = ~r3[BIT_UP];
    n[5] = ~r3[BIT_DOWN];
    n[6] = ~r3[BIT_LEFT];
    n[7] = ~r3[BIT_RIGHT];
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psx_pad_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : psx_pad_ctrl_if
// Purpose  : Pad pin bundle between the poller (master) and the game pad
//            (slave).
// Signals  : PAD_SEL1n  select, active-low      (master -> pad)
//            PAD_CLK    serial clock, idle high  (master -> pad)
//            PAD_CMD    command data, LSB first  (master -> pad)
//            PAD_DAT    response data, LSB first (pad -> master)
//            PAD_ACKn   byte acknowledge, low    (pad -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface psx_pad_ctrl_if;
  logic PAD_SEL1n;
  logic PAD_CLK;
  logic PAD_CMD;
  logic PAD_DAT;
  logic PAD_ACKn;

  modport master (output PAD_SEL1n, output PAD_CLK, output PAD_CMD,
                  input  PAD_DAT,   input  PAD_ACKn);
  modport slave  (input  PAD_SEL1n, input  PAD_CLK, input  PAD_CMD,
                  output PAD_DAT,   output PAD_ACKn);
endinterface
`default_nettype wire

// File: rtl/psx_pad_ctrl_shifter.sv
`default_nettype none
// ============================================================================
// Module   : psx_pad_shifter
// Purpose  : Full-duplex one-byte serial transfer. Each bit: clock falls with
//            the next command bit, after CLK_DIV cycles clock rises and the
//            response bit is sampled, then CLK_DIV more cycles of high time.
// Ports    : m_clock, p_reset  clock / synchronous active-high reset
//            i_start           begin a byte (ignored while active)
//            i_tx_byte         command byte, sent LSB first
//            i_dat             synchronised response data
//            o_rx_byte         received byte, LSB first
//            o_done            one-cycle strobe after the eighth bit
//            o_pad_clk         serial clock, idle high
//            o_pad_cmd         command line, idle high
// Revision : 1.0 - initial release
// ============================================================================
module psx_pad_shifter #(
  parameter int CLK_DIV = 100
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       i_start,
  input  logic [7:0] i_tx_byte,
  input  logic       i_dat,
  output logic [7:0] o_rx_byte,
  output logic       o_done,
  output logic       o_pad_clk,
  output logic       o_pad_cmd
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          r_active;
  logic          r_high;     // second half of the bit (clock high)
  logic [2:0]    r_bit;
  logic [DW-1:0] r_div;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          r_clk;
  logic          r_cmd;
  logic          r_done;
  logic          w_div_end;

  assign w_div_end = (r_div == DIV_LAST);

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      r_active <= 1'b0;
      r_high   <= 1'b0;
      r_bit    <= 3'd0;
      r_div    <= '0;
      r_tx     <= 8'h00;
      r_rx     <= 8'h00;
      r_clk    <= 1'b1;
      r_cmd    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_active) begin
        r_active <= 1'b1;
        r_high   <= 1'b0;
        r_bit    <= 3'd0;
        r_div    <= '0;
        r_tx     <= i_tx_byte;
        r_clk    <= 1'b0;
        r_cmd    <= i_tx_byte[0];
      end else if (r_active) begin
        if (!w_div_end) begin
          r_div <= r_div + 1'b1;
        end else begin
          r_div <= '0;
          if (!r_high) begin
            r_clk  <= 1'b1;
            r_high <= 1'b1;
            r_rx   <= {i_dat, r_rx[7:1]};
          end else if (r_bit == 3'd7) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_cmd    <= 1'b1;
          end else begin
            r_bit  <= r_bit + 3'd1;
            r_high <= 1'b0;
            r_clk  <= 1'b0;
            r_cmd  <= r_tx[r_bit + 3'd1];
          end
        end
      end
    end
  end

  assign o_rx_byte = r_rx;
  assign o_done    = r_done;
  assign o_pad_clk = r_clk;
  assign o_pad_cmd = r_cmd;

endmodule
`default_nettype wire

// File: rtl/psx_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psx_pad_ctrl
// Purpose  : Polls a PlayStation-style serial pad and presents the decoded
//            buttons as an 8-bit NES controller image.
// Ports    : m_clock, p_reset  50 MHz clock / synchronous active-high reset
//            poll_req          one-cycle request for an immediate poll
//            pad               pad pins (psx_pad_ctrl_if.master)
//            buttons           raw buttons, active-high
//            nes_pad           A,B,Select,Start,Up,Down,Left,Right (bit0..7)
//            pad_id            last accepted ID byte
//            update            one-cycle strobe on a good frame
//            valid / error     sticky good-frame / failed-frame flags
//            busy              transaction in progress
//            stick             {r8,r7,r6,r5} (PAD_ANALOG_EN only)
// Config   : PAD_ANALOG_EN - 9-byte frame, accepts ID 0x73, adds stick port.
// Revision : 1.0 - initial release
// ============================================================================
module psx_pad_ctrl
  import pad_pkg::*;
#(
  parameter int CLK_DIV     = 100,
  parameter int POLL_PERIOD = 833333,
  parameter int ACK_TIMEOUT = 1000,
  parameter int SEL_SETUP   = 1000
) (
  input  logic           m_clock,
  input  logic           p_reset,
  input  logic           poll_req,
  psx_pad_ctrl_if.master pad,
  output logic [15:0]    buttons,
  output logic [7:0]     nes_pad,
  output logic [7:0]     pad_id,
  output logic           update,
  output logic           valid,
  output logic           busy,
  output logic           error
`ifdef PAD_ANALOG_EN
  ,
  output logic [31:0]    stick
`endif
);

  localparam int FW    = 8 * (NUM_BYTES - 1);
  localparam int PW    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int T_MAX = (SEL_SETUP > ACK_TIMEOUT)
                         ? ((SEL_SETUP > 2*CLK_DIV) ? SEL_SETUP : 2*CLK_DIV)
                         : ((ACK_TIMEOUT > 2*CLK_DIV) ? ACK_TIMEOUT : 2*CLK_DIV);
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] T_SETUP   = TW'(SEL_SETUP - 1);
  localparam logic [TW-1:0] T_ACK     = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_DONE    = TW'(2*CLK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [3:0]    LAST_BYTE = 4'(NUM_BYTES - 1);

  pad_state_t    r_state, w_next;
  logic [TW-1:0] r_tmr;
  logic [PW-1:0] r_poll_cnt;
  logic          r_dat_s1, r_dat_s2, r_ack_s1, r_ack_s2;
  logic [3:0]    r_byte_idx;
  logic [FW-1:0] r_frame;     // response bytes r1..rN, r1 in the low byte
  logic          r_sel_n;
  logic [15:0]   r_buttons;
  logic [7:0]    r_nes, r_id;
  logic          r_update, r_valid, r_error;

  logic          w_poll_exp, w_sh_start, w_sh_done, w_id_ok, w_frame_ok;
  logic [7:0]    w_sh_rx, w_r1, w_r2, w_r3, w_r4;

  assign w_poll_exp = (r_poll_cnt == POLL_LAST);

  // Bytes shift in from the top, so after the last byte r0 has fallen out of
  // the bottom and r1 sits in the low byte.
  assign w_r1 = r_frame[7:0];
  assign w_r2 = r_frame[15:8];
  assign w_r3 = r_frame[23:16];
  assign w_r4 = r_frame[31:24];

`ifdef PAD_ANALOG_EN
  assign w_id_ok = (w_r1 == ID_DIGITAL) || (w_r1 == ID_ANALOG);
`else
  assign w_id_ok = (w_r1 == ID_DIGITAL);
`endif
  assign w_frame_ok = w_id_ok && (w_r2 == ID_READY);

  psx_pad_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .m_clock   (m_clock),
    .p_reset   (p_reset),
    .i_start   (w_sh_start),
    .i_tx_byte (cmd_byte(r_byte_idx)),
    .i_dat     (r_dat_s2),
    .o_rx_byte (w_sh_rx),
    .o_done    (w_sh_done),
    .o_pad_clk (pad.PAD_CLK),
    .o_pad_cmd (pad.PAD_CMD)
  );

  always_comb begin
    w_next     = r_state;
    w_sh_start = 1'b0;
    unique case (r_state)
      ST_IDLE:    if (poll_req || w_poll_exp) w_next = ST_SETUP;
      ST_SETUP:   if (r_tmr == T_SETUP) begin
                    w_next     = ST_SHIFT;
                    w_sh_start = 1'b1;
                  end
      ST_SHIFT:   if (w_sh_done) w_next = (r_byte_idx == LAST_BYTE) ? ST_CHECK : ST_ACKWAIT;
      ST_ACKWAIT: if (!r_ack_s2) begin
                    w_next     = ST_SHIFT;
                    w_sh_start = 1'b1;
                  end else if (r_tmr == T_ACK) begin
                    w_next = ST_FAIL;
                  end
      ST_CHECK:   w_next = w_frame_ok ? ST_DONE : ST_FAIL;
      ST_FAIL:    w_next = ST_DONE;
      ST_DONE:    if (r_tmr == T_DONE) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_poll_cnt <= '0;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_ack_s1   <= 1'b1;
      r_ack_s2   <= 1'b1;
      r_byte_idx <= 4'd0;
      r_frame    <= '0;
      r_sel_n    <= 1'b1;
      r_buttons  <= 16'h0000;
      r_nes      <= 8'h00;
      r_id       <= 8'h00;
      r_update   <= 1'b0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_tmr      <= (w_next != r_state) ? '0 : r_tmr + 1'b1;
      r_poll_cnt <= w_poll_exp ? '0 : r_poll_cnt + 1'b1;
      r_dat_s1   <= pad.PAD_DAT;
      r_dat_s2   <= r_dat_s1;
      r_ack_s1   <= pad.PAD_ACKn;
      r_ack_s2   <= r_ack_s1;
      r_sel_n    <= !(w_next inside {ST_SETUP, ST_SHIFT, ST_ACKWAIT, ST_CHECK, ST_FAIL});
      r_update   <= 1'b0;

      if (r_state == ST_SETUP) r_byte_idx <= 4'd0;
      if (r_state == ST_SHIFT && w_sh_done) begin
        r_byte_idx <= r_byte_idx + 4'd1;
        r_frame    <= {w_sh_rx, r_frame[FW-1:8]};
      end

      if (r_state == ST_CHECK && w_frame_ok) begin
        r_buttons <= ~{w_r4, w_r3};
        r_nes     <= nes_map(w_r3, w_r4);
        r_id      <= w_r1;
        r_update  <= 1'b1;
        r_valid   <= 1'b1;
        r_error   <= 1'b0;
      end
      if (r_state == ST_FAIL) begin
        r_valid <= 1'b0;
        r_error <= 1'b1;
      end
    end
  end

`ifdef PAD_ANALOG_EN
  logic [31:0] r_stick;
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      r_stick <= 32'h8080_8080;
    end else if (r_state == ST_CHECK && w_frame_ok) begin
      // A digital-mode pad sends no stick bytes worth trusting: park centred.
      r_stick <= (w_r1 == ID_DIGITAL) ? 32'h8080_8080 : r_frame[FW-1:32];
    end
  end
  assign stick = r_stick;
`endif

  assign pad.PAD_SEL1n = r_sel_n;
  assign buttons       = r_buttons;
  assign nes_pad       = r_nes;
  assign pad_id        = r_id;
  assign update        = r_update;
  assign valid         = r_valid;
  assign error         = r_error;
  assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_psx_pad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_psx_pad_ctrl
// Purpose  : Self-checking bench for psx_pad_ctrl. A pad model answers each
//            frame from a configurable response table and pushes the expected
//            post-frame outputs into a queue; a monitor pops and compares at
//            the end of every transaction.
// Config   : PAD_ANALOG_EN - also exercises the stick port.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_psx_pad_ctrl;

  localparam int CLK_DIV     = 4;
  localparam int POLL_PERIOD = 3000;
  localparam int ACK_TIMEOUT = 60;
  localparam int SEL_SETUP   = 20;
`ifdef PAD_ANALOG_EN
  localparam bit ANALOG = 1'b1;
  localparam int NB     = 9;
`else
  localparam bit ANALOG = 1'b0;
  localparam int NB     = 5;
`endif
  // Source (response byte, bit) for each NES bit A,B,Sel,Start,U,D,L,R.
  localparam int NES_BYTE [8] = '{4, 4, 3, 3, 3, 3, 3, 3};
  localparam int NES_BIT  [8] = '{5, 6, 0, 3, 4, 6, 7, 5};

  typedef struct {
    bit          good;
    logic [15:0] buttons;
    logic [7:0]  nes;
    logic [7:0]  id;
    logic [31:0] stick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_req = 1'b0;
  logic [15:0] buttons;
  logic [7:0]  nes_pad, pad_id;
  logic        update, valid, busy, error;
  logic [31:0] stick_obs;

  psx_pad_ctrl_if pad ();

`ifdef PAD_ANALOG_EN
  logic [31:0] stick;
  assign stick_obs = stick;
`else
  assign stick_obs = 32'h8080_8080;
`endif

  psx_pad_ctrl #(
    .CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL_PERIOD),
    .ACK_TIMEOUT(ACK_TIMEOUT), .SEL_SETUP(SEL_SETUP)
  ) dut (
    .m_clock (clk),
    .p_reset (rst),
    .poll_req(poll_req),
    .pad     (pad),
    .buttons (buttons),
    .nes_pad (nes_pad),
    .pad_id  (pad_id),
    .update  (update),
    .valid   (valid),
    .busy    (busy),
    .error   (error)
`ifdef PAD_ANALOG_EN
    ,
    .stick   (stick)
`endif
  );

  always #10 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_frames = 0;
  exp_t exp_q[$];

  // Response table the stimulus configures; snapshotted at each select.
  logic [7:0] cfg_resp [9];
  bit         cfg_ack;
  // Reference state: what the outputs should hold after the last frame.
  logic [15:0] m_buttons = 16'h0;
  logic [7:0]  m_nes = 8'h0, m_id = 8'h0;
  logic [31:0] m_stick = 32'h8080_8080;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- pad model
  logic [7:0] fr_resp [9];
  bit         fr_ack;
  int         pm_byte, pm_bit, ack_cd, ack_hold;
  logic [7:0] cmd_acc, exp_cmd;
  logic       prev_sel = 1'b1, prev_pclk = 1'b1;
  bit         good;
  exp_t       e_new;

  initial begin
    pad.PAD_DAT  = 1'b1;
    pad.PAD_ACKn = 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      pm_byte = 0; pm_bit = 0; ack_cd = 0; ack_hold = 0;
      pad.PAD_ACKn = 1'b1;
      pad.PAD_DAT  = 1'b1;
    end else begin
      if (prev_sel && !pad.PAD_SEL1n) begin
        fr_resp = cfg_resp;
        fr_ack  = cfg_ack;
        pm_byte = 0; pm_bit = 0;
        n_frames++;
        good = fr_ack && (fr_resp[2] == 8'h5A) &&
               ((fr_resp[1] == 8'h41) || (ANALOG && fr_resp[1] == 8'h73));
        if (good) begin
          m_buttons = ~{fr_resp[4], fr_resp[3]};
          for (int k = 0; k < 8; k++) m_nes[k] = ~fr_resp[NES_BYTE[k]][NES_BIT[k]];
          m_id    = fr_resp[1];
          m_stick = (fr_resp[1] == 8'h73) ? {fr_resp[8], fr_resp[7], fr_resp[6], fr_resp[5]}
                                          : 32'h8080_8080;
        end
        e_new.good = good; e_new.buttons = m_buttons; e_new.nes = m_nes;
        e_new.id = m_id; e_new.stick = m_stick;
        exp_q.push_back(e_new);
      end
      if (!pad.PAD_SEL1n && pm_byte < NB) begin
        if (prev_pclk && !pad.PAD_CLK) pad.PAD_DAT = fr_resp[pm_byte][pm_bit];
        if (!prev_pclk && pad.PAD_CLK) begin
          cmd_acc[pm_bit] = pad.PAD_CMD;
          pm_bit++;
          if (pm_bit == 8) begin
            exp_cmd = (pm_byte == 0) ? 8'h01 : (pm_byte == 1) ? 8'h42 : 8'h00;
            check("cmd_byte", 32'(cmd_acc), 32'(exp_cmd));
            pm_byte++;
            pm_bit = 0;
            if (fr_ack && pm_byte < NB) ack_cd = $urandom_range(20, 6);
          end
        end
      end
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) ack_hold = 4;
      end
      if (ack_hold > 0) begin
        pad.PAD_ACKn = 1'b0;
        ack_hold--;
      end else begin
        pad.PAD_ACKn = 1'b1;
      end
    end
    prev_sel  = pad.PAD_SEL1n;
    prev_pclk = pad.PAD_CLK;
  end

  // ------------------------------------------------------------------ monitor
  logic mon_busy_prev = 1'b0;
  int   upd_cnt = 0;
  exp_t e_mon;

  always @(negedge clk) begin
    if (busy === 1'b1 && !mon_busy_prev) upd_cnt = 0;
    if (update === 1'b1) upd_cnt++;
    if (busy === 1'b0 && mon_busy_prev) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_txn: got a transaction end, required none pending");
      end else begin
        e_mon = exp_q.pop_front();
        if (!rst) begin
          check("error",        32'(error),   32'(!e_mon.good));
          check("valid",        32'(valid),   32'(e_mon.good));
          check("buttons",      32'(buttons), 32'(e_mon.buttons));
          check("nes_pad",      32'(nes_pad), 32'(e_mon.nes));
          check("pad_id",       32'(pad_id),  32'(e_mon.id));
          check("update_count", 32'(upd_cnt), 32'(e_mon.good ? 1 : 0));
          if (ANALOG) check("stick", stick_obs, e_mon.stick);
        end
      end
    end
    mon_busy_prev = (busy === 1'b1);
  end

  // ----------------------------------------------------------------- stimulus
  task automatic set_cfg(input logic [7:0] id, input logic [7:0] r2, input logic [7:0] r3,
                         input logic [7:0] r4, input bit ack, input logic [31:0] st);
    cfg_resp[0] = 8'hFF; cfg_resp[1] = id; cfg_resp[2] = r2;
    cfg_resp[3] = r3;    cfg_resp[4] = r4;
    cfg_resp[5] = st[7:0];   cfg_resp[6] = st[15:8];
    cfg_resp[7] = st[23:16]; cfg_resp[8] = st[31:24];
    cfg_ack = ack;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    if (busy) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: busy still 1, required 0", name);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_poll(input string name);
    int n;
    @(negedge clk); poll_req = 1'b1;
    @(negedge clk); poll_req = 1'b0;
    n = 0;
    while (!busy && n < 5) begin @(negedge clk); n++; end
    if (!busy) begin
      n_tests++; n_fail++;
      $display("FAIL %s_start: busy 0, required 1", name);
    end
    wait_idle(name);
  endtask

  task automatic wait_auto(input string name);
    int n;
    n = 0;
    while (pad.PAD_SEL1n && n < POLL_PERIOD + 100) begin @(negedge clk); n++; end
    check(name, 32'(pad.PAD_SEL1n), 32'd1 - 32'd1);
    wait_idle(name);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel"},     32'(pad.PAD_SEL1n), 32'd1);
    check({tag, "_pclk"},    32'(pad.PAD_CLK),   32'd1);
    check({tag, "_pcmd"},    32'(pad.PAD_CMD),   32'd1);
    check({tag, "_buttons"}, 32'(buttons),       32'd0);
    check({tag, "_nes"},     32'(nes_pad),       32'd0);
    check({tag, "_id"},      32'(pad_id),        32'd0);
    check({tag, "_flags"},   32'({update, valid, busy, error}), 32'd0);
    if (ANALOG) check({tag, "_stick"}, stick_obs, 32'h8080_8080);
  endtask

  logic [7:0]  s_id, s_r2, s_r3, s_r4;
  logic [31:0] s_st;
  bit          s_ack;
  int          kind, f0, nw;

  initial begin
    set_cfg(8'h41, 8'h5A, 8'hFF, 8'hFF, 1'b1, 32'h0);
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk); rst = 1'b0;

    // Start + cross pressed.
    set_cfg(8'h41, 8'h5A, 8'hF7, 8'hBF, 1'b1, 32'h0);
    do_poll("good_start_b");

    // Pad never acknowledges: frame fails, previous image kept.
    set_cfg(8'h41, 8'h5A, 8'h00, 8'h00, 1'b0, 32'h0);
    do_poll("no_ack");
    check("no_ack_sel_high", 32'(pad.PAD_SEL1n), 32'd1);

    // Bad ready byte, then a good frame clears the error.
    set_cfg(8'h41, 8'h00, 8'h00, 8'h00, 1'b1, 32'h0);
    do_poll("bad_r2");
    set_cfg(8'h41, 8'h5A, 8'hEE, 8'h7D, 1'b1, 32'h0);
    do_poll("recover");

    // Held request plus a re-pulse while busy yields one select period.
    f0 = n_frames;
    @(negedge clk); poll_req = 1'b1;
    repeat (3) @(negedge clk); poll_req = 1'b0;
    repeat (40) @(negedge clk);
    poll_req = 1'b1; @(negedge clk); poll_req = 1'b0;
    wait_idle("held_req");
    check("single_sel_period", 32'(n_frames - f0), 32'd1);

    // Automatic poll from the period counter.
    set_cfg(8'h41, 8'h5A, 8'hAF, 8'hDB, 1'b1, 32'h0);
    wait_auto("auto_poll");

    for (int i = 0; i < 14; i++) begin
      kind  = $urandom_range(9, 0);
      s_id  = (ANALOG && $urandom_range(1, 0) == 1) ? 8'h73 : 8'h41;
      s_r2  = 8'h5A;
      s_r3  = 8'($urandom);
      s_r4  = 8'($urandom);
      s_st  = $urandom;
      s_ack = 1'b1;
      if (kind == 7) s_id = 8'h23;
      if (kind == 8) begin
        s_r2 = 8'($urandom_range(255, 0));
        if (s_r2 == 8'h5A) s_r2 = 8'h00;
      end
      if (kind == 9) s_ack = 1'b0;
      set_cfg(s_id, s_r2, s_r3, s_r4, s_ack, s_st);
      if (i % 7 == 6) wait_auto("auto_rand");
      else do_poll("rand");
    end

    // Reset during byte 2 aborts the transaction.
    set_cfg(8'h41, 8'h5A, 8'h5A, 8'hA5, 1'b1, 32'h0);
    @(negedge clk); poll_req = 1'b1;
    @(negedge clk); poll_req = 1'b0;
    nw = 0;
    while (!(pm_byte == 2 && pm_bit >= 2) && nw < 2000) begin @(negedge clk); nw++; end
    check("reach_byte2", 32'(pm_byte), 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_buttons = 16'h0; m_nes = 8'h0; m_id = 8'h0; m_stick = 32'h8080_8080;

    set_cfg(8'h41, 8'h5A, 8'hFE, 8'hFF, 1'b1, 32'h0);
    do_poll("post_reset");

`ifdef PAD_ANALOG_EN
    set_cfg(8'h73, 8'h5A, 8'hFF, 8'hFF, 1'b1, 32'h4030_2010);
    do_poll("analog");
    check("analog_stick", stick_obs, 32'h4030_2010);
    check("analog_nes",   32'(nes_pad), 32'h00);
`endif

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
